// File: rtl/tuner_pkg.sv
// ============================================================================
// tuner_pkg : shared types and constants for the freq_tuner block
// Rev 1.0
// ============================================================================
`default_nettype none

package tuner_pkg;

  localparam int FREQ_W = 11;

  typedef logic [6:0] seg_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } bcd_state_e;

  localparam seg_t SEG_LUT [10] = '{
    7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66,
    7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f
  };

  function automatic seg_t digit_seg(input logic [3:0] d);
    digit_seg = (d > 4'd9) ? 7'h00 : SEG_LUT[d];
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// key_debounce : synchroniser, debounce filter and press pulse with optional repeat
// Rev 1.0
// ============================================================================
`default_nettype none

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_key_n,
  output logic o_press
);

  logic [1:0]  r_sync;
  logic        r_level;
  logic        r_level_q;
  logic [31:0] r_db_cnt;
  logic        w_fall;

  // Level only flips after the synchronised input disagrees for the full window
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync    <= 2'b11;
      r_level   <= 1'b1;
      r_level_q <= 1'b1;
      r_db_cnt  <= '0;
    end else begin
      r_sync    <= {r_sync[0], i_key_n};
      r_level_q <= r_level;
      if (r_sync[1] != r_level) begin
        if (r_db_cnt == 32'(DEBOUNCE_CYCLES - 1)) begin
          r_level  <= r_sync[1];
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 32'd1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_fall = r_level_q & ~r_level;

  generate
    if (REPEAT_EN) begin : g_repeat
      logic [31:0] r_rpt_cnt;
      logic        r_rpt_first;
      logic [31:0] w_target;
      logic        w_rpt;

      assign w_target = r_rpt_first ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_PERIOD - 1);
      assign w_rpt    = ~r_level & ~w_fall & (r_rpt_cnt == w_target);

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_rpt_cnt   <= '0;
          r_rpt_first <= 1'b1;
        end else if (r_level || w_fall) begin
          r_rpt_cnt   <= '0;
          r_rpt_first <= 1'b1;
        end else if (w_rpt) begin
          r_rpt_cnt   <= '0;
          r_rpt_first <= 1'b0;
        end else begin
          r_rpt_cnt   <= r_rpt_cnt + 32'd1;
        end
      end

      assign o_press = w_fall | w_rpt;
    end else begin : g_no_repeat
      assign o_press = w_fall;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/freq_tuner.sv
// ============================================================================
// freq_tuner : push-button/preset FM tuner with DDS constant and 7-seg readout
// Rev 1.0
// ============================================================================
`default_nettype none

module freq_tuner
  import tuner_pkg::*;
#(
  parameter int width_dds       = 32,
  parameter int N_PRESETS       = 5,
  parameter int PRESETS [N_PRESETS] = '{877, 893, 937, 981, 1079},
  parameter int F_MIN           = 875,
  parameter int F_MAX           = 1080,
  parameter int F_RESET         = 1000,
  parameter int K_STEP          = 1789570,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 key_up_n,
  input  logic                 key_down_n,
  input  logic                 key_preset_n,
  input  logic [N_PRESETS-1:0] SW,
  output logic [FREQ_W-1:0]    freq,
  output logic [width_dds-1:0] K,
  output logic                 k_update,
  output seg_t                 HEX [4]
);

  localparam int SR_W = 16 + FREQ_W;

  generate
    for (genvar gi = 0; gi < N_PRESETS; gi++) begin : g_preset_chk
      if (PRESETS[gi] < F_MIN || PRESETS[gi] > F_MAX) begin : g_bad
        $error("freq_tuner: PRESETS[%0d] lies outside the tuning band", gi);
      end
    end
  endgenerate

  logic w_up_ev, w_dn_ev, w_pre_ev;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b1),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_key_up (
    .clk(clk), .reset_n(reset_n), .i_key_n(key_up_n), .o_press(w_up_ev)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b1),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_key_down (
    .clk(clk), .reset_n(reset_n), .i_key_n(key_down_n), .o_press(w_dn_ev)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b0),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_key_preset (
    .clk(clk), .reset_n(reset_n), .i_key_n(key_preset_n), .o_press(w_pre_ev)
  );

  logic [FREQ_W-1:0]    r_freq;
  logic [FREQ_W-1:0]    w_freq_next;
  logic [FREQ_W-1:0]    w_preset_val;
  logic                 w_sw_onehot;
  logic                 w_freq_chg;
  logic [width_dds-1:0] r_k;
  logic [width_dds-1:0] w_k_next;
  logic                 r_kupd;

  always_comb begin
    w_sw_onehot  = $onehot(SW);
    w_preset_val = '0;
    for (int i = 0; i < N_PRESETS; i++) begin
      if (SW[i]) w_preset_val = FREQ_W'(PRESETS[i]);
    end
  end

  // An invalid switch pattern drops the preset press entirely, so up/down still act
  always_comb begin
    w_freq_next = r_freq;
    if (w_pre_ev && w_sw_onehot) begin
      w_freq_next = w_preset_val;
    end else if (w_up_ev ^ w_dn_ev) begin
      if (w_up_ev) begin
        w_freq_next = (r_freq == FREQ_W'(F_MAX)) ? FREQ_W'(F_MIN) : r_freq + 1'b1;
      end else begin
        w_freq_next = (r_freq == FREQ_W'(F_MIN)) ? FREQ_W'(F_MAX) : r_freq - 1'b1;
      end
    end
  end

  assign w_freq_chg = (w_freq_next != r_freq);
  assign w_k_next   = width_dds'(r_freq) * width_dds'(K_STEP);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_freq <= FREQ_W'(F_RESET);
      r_k    <= width_dds'(F_RESET) * width_dds'(K_STEP);
      r_kupd <= 1'b0;
    end else begin
      r_freq <= w_freq_next;
      r_k    <= w_k_next;
      r_kupd <= (w_k_next != r_k);
    end
  end

  assign freq     = r_freq;
  assign K        = r_k;
  assign k_update = r_kupd;

  bcd_state_e      r_state, w_state_next;
  logic            r_pend;
  logic [SR_W-1:0] r_sr;
  logic [SR_W-1:0] w_sr_shift;
  logic [15:0]     w_bcd_adj;
  logic [3:0]      r_bit_cnt;
  seg_t            r_hex [4];

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (r_pend) w_state_next = ST_SHIFT;
      ST_SHIFT: if (r_bit_cnt == 4'(FREQ_W - 1)) w_state_next = ST_LOAD;
      ST_LOAD:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_bcd_adj = r_sr[SR_W-1:FREQ_W];
    for (int n = 0; n < 4; n++) begin
      if (w_bcd_adj[4*n +: 4] >= 4'd5) w_bcd_adj[4*n +: 4] = w_bcd_adj[4*n +: 4] + 4'd3;
    end
    w_sr_shift = {w_bcd_adj[14:0], r_sr[FREQ_W-1:0], 1'b0};
  end

  // A change arriving in the capture cycle keeps pending set for the next pass
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pend    <= 1'b1;
      r_sr      <= '0;
      r_bit_cnt <= '0;
      for (int d = 0; d < 4; d++) r_hex[d] <= '0;
    end else begin
      r_pend <= (r_state == ST_IDLE && r_pend) ? w_freq_chg : (r_pend | w_freq_chg);
      case (r_state)
        ST_IDLE: begin
          if (r_pend) begin
            r_sr      <= {16'd0, r_freq};
            r_bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          r_sr      <= w_sr_shift;
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
        ST_LOAD: begin
          r_hex[0] <= digit_seg(r_sr[FREQ_W +: 4]);
          r_hex[1] <= digit_seg(r_sr[FREQ_W+4 +: 4]);
          r_hex[2] <= digit_seg(r_sr[FREQ_W+8 +: 4]);
          r_hex[3] <= (r_sr[FREQ_W+12 +: 4] == 4'd0) ? 7'h00 : digit_seg(r_sr[FREQ_W+12 +: 4]);
        end
        default: ;
      endcase
    end
  end

  assign HEX = r_hex;

endmodule

`default_nettype wire

// File: tb/tb_freq_tuner.sv
// ============================================================================
// tb_freq_tuner : directed self-checking bench for freq_tuner
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_freq_tuner;
  import tuner_pkg::*;

  localparam logic [27:0] H_BLANK = 28'h0;
  localparam logic [27:0] H1000   = {7'h06, 7'h3f, 7'h3f, 7'h3f};
  localparam logic [27:0] H875    = {7'h00, 7'h7f, 7'h07, 7'h6d};
  localparam logic [27:0] H978    = {7'h00, 7'h6f, 7'h07, 7'h7f};
  localparam logic [27:0] H979    = {7'h00, 7'h6f, 7'h07, 7'h6f};
  localparam logic [27:0] H981    = {7'h00, 7'h6f, 7'h7f, 7'h06};

  logic        clk;
  logic        reset_n;
  logic        key_up_n, key_down_n, key_preset_n;
  logic [4:0]  SW;
  logic [10:0] freq;
  logic [31:0] K;
  logic        k_update;
  seg_t        HEX [4];
  logic [27:0] hexp;

  int errors = 0;
  int checks = 0;
  int kcnt   = 0;
  int kbase;

  freq_tuner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .key_up_n(key_up_n), .key_down_n(key_down_n), .key_preset_n(key_preset_n),
    .SW(SW), .freq(freq), .K(K), .k_update(k_update), .HEX(HEX)
  );

  assign hexp = {HEX[3], HEX[2], HEX[1], HEX[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (k_update === 1'b1) kcnt <= kcnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // which: 0 up, 1 down, 2 preset, 3 up+down together
  task automatic press(input int which, input int hold);
    @(posedge clk); #1;
    case (which)
      0: key_up_n = 1'b0;
      1: key_down_n = 1'b0;
      2: key_preset_n = 1'b0;
      default: begin key_up_n = 1'b0; key_down_n = 1'b0; end
    endcase
    repeat (hold) @(posedge clk);
    #1;
    key_up_n = 1'b1; key_down_n = 1'b1; key_preset_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_freq(input string tag, input logic [10:0] exp);
    int n = 0;
    while (freq !== exp && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(freq), 64'(exp));
  endtask

  task automatic wait_hex_change(input string tag, input logic [27:0] exp);
    logic [27:0] old = hexp;
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (hexp == old && n < 60);
    check(tag, 64'(hexp), 64'(exp));
  endtask

  initial begin
    reset_n = 1'b0; key_up_n = 1'b1; key_down_n = 1'b1; key_preset_n = 1'b1; SW = '0;

    // Reset state and first conversion timing
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_freq", 64'(freq), 64'd1000);
    check("rst_K", 64'(K), 64'd1789570000);
    check("rst_kupd", 64'(k_update), 64'd0);
    check("rst_hex", 64'(hexp), 64'(H_BLANK));
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("hex_cyc12_blank", 64'(hexp), 64'(H_BLANK));
    @(posedge clk);
    @(negedge clk);
    check("hex_cyc13_1000", 64'(hexp), 64'(H1000));
    check("kupd_after_rst", 64'(kcnt), 64'd0);

    // Preset to top of band, step up, wrap
    SW = 5'b10000;
    press(2, 10);
    check("preset_1079", 64'(freq), 64'd1079);
    check("K_1079", 64'(K), 64'd1930946030);
    press(0, 10);
    check("up_1080", 64'(freq), 64'd1080);
    press(0, 10);
    check("up_wrap_875", 64'(freq), 64'd875);
    check("K_875", 64'(K), 64'd1565873750);
    check("hex_875", 64'(hexp), 64'(H875));

    // One-hot presets, single k_update pulse; invalid pattern ignored
    SW = 5'b00100;
    kbase = kcnt;
    press(2, 10);
    check("preset_937", 64'(freq), 64'd937);
    check("K_937", 64'(K), 64'd1676827090);
    check("kupd_937_once", 64'(kcnt - kbase), 64'd1);
    SW = 5'b01000;
    kbase = kcnt;
    press(2, 10);
    check("preset_981", 64'(freq), 64'd981);
    check("K_981", 64'(K), 64'd1755568170);
    check("kupd_981_once", 64'(kcnt - kbase), 64'd1);
    SW = 5'b00110;
    kbase = kcnt;
    press(2, 10);
    check("preset_multi_ignored", 64'(freq), 64'd981);
    check("kupd_multi_none", 64'(kcnt - kbase), 64'd0);

    // Glitch shorter than the debounce window, then held key with auto-repeat
    @(posedge clk); #1;
    key_up_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    key_up_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("glitch_no_change", 64'(freq), 64'd981);
    press(1, 36);
    check("hold_down_3", 64'(freq), 64'd978);

    // Up and down together cancel
    press(3, 10);
    check("up_down_cancel", 64'(freq), 64'd978);
    check("hex_978", 64'(hexp), 64'(H978));

    // Change during SHIFT: old conversion completes first, then the new value
    @(posedge clk); #1;
    key_up_n = 1'b0;
    wait_freq("up_979", 11'd979);
    SW = 5'b01000;
    key_preset_n = 1'b0;
    key_up_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    key_preset_n = 1'b1;
    wait_hex_change("hex_first_979", H979);
    wait_hex_change("hex_then_981", H981);
    check("freq_981_mid", 64'(freq), 64'd981);

    // Reset in the middle of a conversion
    @(posedge clk); #1;
    key_up_n = 1'b0;
    wait_freq("up_982", 11'd982);
    key_up_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_freq", 64'(freq), 64'd1000);
    check("midrst_hex", 64'(hexp), 64'(H_BLANK));
    check("midrst_K", 64'(K), 64'd1789570000);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (13) @(posedge clk);
    @(negedge clk);
    check("midrst_hex_1000", 64'(hexp), 64'(H1000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
